// File: rtl/uart_fifo_device.sv
// uart_fifo_device: FIFO-buffered UART with 8-bit register bus, programmable frame format and maskable interrupts.
module uart_fifo_device_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [7:0] level,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push & (~full | pop);
  assign do_pop = pop & ~empty;
  assign dout = mem[rp];
  assign level = 8'(cnt);
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst | flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

module uart_fifo_device #(
  parameter int DATA_BITS = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       we,
  input  logic [2:0] adr,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  input  logic       rx,
  output logic       tx,
  output logic       inter
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [2:0] LAST = 3'(DATA_BITS - 1);
  localparam logic [7:0] MASK = 8'((1 << DATA_BITS) - 1);
  logic [6:0] ctrl;
  logic [15:0] div, bcnt;
  logic [7:0] thr, rx_head, tx_head, rx_lvl, tx_lvl, status;
  logic fe, pe_f, ovr, txo, fe_set, pe_set, ovr_set;
  logic tick, flush, wr_tx, wr_st, rd_rx;
  logic rx_full, rx_empty, tx_full, tx_empty, rx_push, tx_pop;
  state_t ts, ts_n, rs, rs_n;
  logic [3:0] tc, tc_n, rc, rc_n;
  logic [2:0] ti, ti_n, ri, ri_n;
  logic [7:0] tw, tw_n, rw, rw_n;
  logic tx_n, rp, rp_n, s1, s2;
  assign wr_tx = ce & we & (adr == 3'd0);
  assign wr_st = ce & we & (adr == 3'd1);
  assign flush = ce & we & (adr == 3'd2) & dat_i[7];
  assign rd_rx = ce & ~we & (adr == 3'd0);
  assign tick = bcnt == '0;
  assign status = {txo, rx_lvl >= thr, tx_empty & (ts == IDLE), tx_full, ovr, pe_f, fe, ~rx_empty};
  uart_fifo_device_fifo #(.DEPTH(FIFO_DEPTH)) rx_fifo (
    .clk(clk), .rst(rst), .flush(flush), .push(rx_push), .pop(rd_rx), .din(rw),
    .dout(rx_head), .level(rx_lvl), .full(rx_full), .empty(rx_empty)
  );
  uart_fifo_device_fifo #(.DEPTH(FIFO_DEPTH)) tx_fifo (
    .clk(clk), .rst(rst), .flush(flush), .push(wr_tx), .pop(tx_pop), .din(dat_i),
    .dout(tx_head), .level(tx_lvl), .full(tx_full), .empty(tx_empty)
  );
  always_comb
    case (adr)
      3'd0: dat_o = rx_empty ? 8'h00 : rx_head;
      3'd1: dat_o = status;
      3'd2: dat_o = {1'b0, ctrl};
      3'd3: dat_o = div[7:0];
      3'd4: dat_o = div[15:8];
      3'd5: dat_o = rx_lvl;
      3'd6: dat_o = tx_lvl;
      default: dat_o = thr;
    endcase
  always_ff @(posedge clk)
    if (rst) begin
      ctrl <= '0;
      div <= '0;
      thr <= 8'd1;
    end else if (ce & we) begin
      if (adr == 3'd2) ctrl <= dat_i[6:0];
      if (adr == 3'd3) div[7:0] <= dat_i;
      if (adr == 3'd4) div[15:8] <= dat_i;
      if (adr == 3'd7) thr <= (dat_i == 8'd0) ? 8'd1 : dat_i;
    end
  // Sticky flags: a hardware set in the same cycle as a W1C clear wins.
  always_ff @(posedge clk)
    if (rst) begin
      fe <= 1'b0;
      pe_f <= 1'b0;
      ovr <= 1'b0;
      txo <= 1'b0;
      inter <= 1'b0;
      bcnt <= '0;
    end else begin
      fe <= fe_set | (fe & ~(wr_st & dat_i[1]));
      pe_f <= pe_set | (pe_f & ~(wr_st & dat_i[2]));
      ovr <= ovr_set | (ovr & ~(wr_st & dat_i[3]));
      txo <= (wr_tx & tx_full & ~tx_pop) | (txo & ~(wr_st & dat_i[7]));
      inter <= (ctrl[0] & status[6]) | (ctrl[1] & status[5]) | (ctrl[2] & (fe | pe_f | ovr | txo));
      bcnt <= tick ? div : bcnt - 16'd1;
    end
  always_comb begin
    ts_n = ts;
    tc_n = tc;
    ti_n = ti;
    tw_n = tw;
    tx_pop = 1'b0;
    if (tick) begin
      tc_n = tc + 4'd1;
      case (ts)
        START: if (tc == 4'd7) begin ts_n = DATA; tc_n = '0; ti_n = '0; end
        DATA: if (tc == 4'd7) begin
          tc_n = '0;
          ti_n = ti + 3'd1;
          if (ti == LAST) ts_n = ctrl[3] ? PARITY : STOP;
        end
        PARITY: if (tc == 4'd7) begin ts_n = STOP; tc_n = '0; end
        STOP: if (tc == (ctrl[5] ? 4'd15 : 4'd7)) ts_n = IDLE;
        default: ;
      endcase
      // Popping here also covers the tick that ends STOP, giving back-to-back frames.
      if (ts_n == IDLE && ~tx_empty) begin
        tx_pop = 1'b1;
        tw_n = tx_head & MASK;
        ts_n = START;
        tc_n = '0;
      end
    end
    tx_n = (ts_n == START) ? 1'b0 : (ts_n == DATA) ? tw_n[ti_n] : (ts_n == PARITY) ? (^tw_n) ^ ~ctrl[4] : 1'b1;
  end
  always_comb begin
    rs_n = rs;
    rc_n = rc;
    ri_n = ri;
    rw_n = rw;
    rp_n = rp;
    rx_push = 1'b0;
    fe_set = 1'b0;
    pe_set = 1'b0;
    ovr_set = 1'b0;
    if (tick) begin
      rc_n = rc + 4'd1;
      case (rs)
        IDLE: if (~s2) begin rs_n = START; rc_n = '0; end
        START: if (rc == 4'd3) begin rs_n = s2 ? IDLE : DATA; rc_n = '0; ri_n = '0; rw_n = '0; end
        DATA: if (rc == 4'd7) begin
          rc_n = '0;
          rw_n[ri] = s2;
          ri_n = ri + 3'd1;
          if (ri == LAST) rs_n = ctrl[3] ? PARITY : STOP;
        end
        PARITY: if (rc == 4'd7) begin rs_n = STOP; rc_n = '0; rp_n = s2; end
        STOP: if (rc == 4'd7) begin
          rs_n = IDLE;
          rx_push = 1'b1;
          ovr_set = rx_full & ~rd_rx;
          fe_set = ~s2;
          pe_set = ctrl[3] & (rp != ((^rw) ^ ~ctrl[4]));
        end
        default: rs_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      ts <= IDLE;
      tc <= '0;
      ti <= '0;
      tw <= '0;
      tx <= 1'b1;
      rs <= IDLE;
      rc <= '0;
      ri <= '0;
      rw <= '0;
      rp <= 1'b0;
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      ts <= ts_n;
      tc <= tc_n;
      ti <= ti_n;
      tw <= tw_n;
      tx <= tx_n;
      rs <= rs_n;
      rc <= rc_n;
      ri <= ri_n;
      rw <= rw_n;
      rp <= rp_n;
      s1 <= ctrl[6] ? tx : rx;
      s2 <= s1;
    end
endmodule

// File: tb/tb_uart_fifo_device.sv
// tb_uart_fifo_device: register table, fixed corner sequences and randomized loopback rounds against a frame/queue model.
module tb_uart_fifo_device;
  localparam int FD = 16;
  logic clk, rst, ce, ce7, we, rx, rx7, tx, tx7, inter, inter7;
  logic [2:0] adr;
  logic [7:0] dat_i, dat_o, dat_o7;
  int checks = 0, failures = 0;

  uart_fifo_device u (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .adr(adr), .dat_i(dat_i),
    .dat_o(dat_o), .rx(rx), .tx(tx), .inter(inter)
  );
  uart_fifo_device #(.DATA_BITS(7)) u7 (
    .clk(clk), .rst(rst), .ce(ce7), .we(we), .adr(adr), .dat_i(dat_i),
    .dat_o(dat_o7), .rx(rx7), .tx(tx7), .inter(inter7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic w;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] e;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ce = 1'b0; ce7 = 1'b0; we = 1'b0; rx = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input logic s, input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    ce = ~s; ce7 = s; we = 1'b1; adr = a; dat_i = d;
    @(negedge clk);
    ce = 1'b0; ce7 = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    ce = 1'b1; we = 1'b0; adr = a;
    #1 d = dat_o;
    @(negedge clk);
    ce = 1'b0;
  endtask

  // Expected line levels of one frame, one entry per bit, LSB first.
  task automatic build_frame(input logic [7:0] d, input int nb, input logic pe, input logic ev,
                             input logic two, output int len, output logic [15:0] b);
    logic p;
    p = ~ev;
    b = '0;
    for (int i = 0; i < nb; i++) begin
      b[1+i] = d[i];
      p ^= d[i];
    end
    len = 1 + nb;
    if (pe) begin b[len] = p; len++; end
    b[len] = 1'b1; len++;
    if (two) begin b[len] = 1'b1; len++; end
  endtask

  task automatic wait_fall(input logic s, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++)
      if ((s ? tx7 : tx) == 1'b0) ok = 1'b1;
      else @(negedge clk);
  endtask

  task automatic cap(input string name, input logic s, input int p, input int len, input logic [15:0] b);
    logic ok;
    int mism;
    wait_fall(s, ok);
    check({name, "_start"}, 16'(ok), 16'd1);
    mism = 0;
    if (ok)
      for (int j = 0; j < len * 8 * p; j++) begin
        if ((s ? tx7 : tx) !== b[j / (8 * p)]) mism++;
        @(negedge clk);
      end
    check({name, "_bits"}, 16'(mism), 16'd0);
  endtask

  task automatic wait_status(input int bitn, input string name);
    logic [7:0] s;
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 8000 && !ok; i++) begin
      rd(3'd1, s);
      ok = s[bitn];
    end
    check(name, 16'(ok), 16'd1);
  endtask

  task automatic round(input logic [6:0] cfg, input logic [7:0] dv, input int n, input logic [7:0] th,
                       input logic [7:0] first, input string name);
    logic [7:0] q[$];
    logic [7:0] d, es;
    logic [15:0] b;
    logic ei;
    int len, lvl, p;
    do_reset();
    wr(1'b0, 3'd3, dv);
    wr(1'b0, 3'd7, th);
    wr(1'b0, 3'd2, {1'b0, cfg});
    q = {first};
    for (int i = 1; i < n; i++) q.push_back(8'($urandom));
    p = int'(dv) + 1;
    build_frame(q[0], 8, cfg[3], cfg[4], cfg[5], len, b);
    wr(1'b0, 3'd0, q[0]);
    cap({name, "_frame"}, 1'b0, p, len, b);
    for (int i = 1; i < n; i++) wr(1'b0, 3'd0, q[i]);
    wait_status(5, {name, "_txidle"});
    repeat (20) @(negedge clk);
    lvl = n > FD ? FD : n;
    es = {1'b0, lvl >= int'(th), 1'b1, 1'b0, n > FD, 2'b00, lvl > 0};
    ei = (cfg[0] & (lvl >= int'(th))) | cfg[1] | (cfg[2] & (n > FD));
    rd(3'd5, d);
    check({name, "_rxlevel"}, 16'(d), 16'(lvl));
    rd(3'd1, d);
    check({name, "_status"}, 16'(d), 16'(es));
    check({name, "_inter"}, 16'(inter), 16'(ei));
    for (int i = 0; i < lvl; i++) begin
      rd(3'd0, d);
      check($sformatf("%s_data%0d", name, i), 16'(d), 16'(q[i]));
    end
    rd(3'd5, d);
    check({name, "_drained"}, 16'(d), 16'd0);
  endtask

  initial begin
    vec_t vt[14];
    logic [7:0] d;
    logic [15:0] b;
    logic ok;
    int len;
    rx7 = 1'b1; adr = '0; dat_i = '0;
    vt[0] = '{1'b0, 3'd1, 8'h00, 8'h20};
    vt[1] = '{1'b0, 3'd5, 8'h00, 8'h00};
    vt[2] = '{1'b0, 3'd6, 8'h00, 8'h00};
    vt[3] = '{1'b0, 3'd7, 8'h00, 8'h01};
    vt[4] = '{1'b0, 3'd2, 8'h00, 8'h00};
    vt[5] = '{1'b0, 3'd0, 8'h00, 8'h00};
    vt[6] = '{1'b1, 3'd7, 8'h00, 8'h01};
    vt[7] = '{1'b1, 3'd7, 8'h09, 8'h09};
    vt[8] = '{1'b1, 3'd3, 8'h5A, 8'h5A};
    vt[9] = '{1'b1, 3'd4, 8'hC3, 8'hC3};
    vt[10] = '{1'b1, 3'd2, 8'h80, 8'h00};
    vt[11] = '{1'b1, 3'd2, 8'h38, 8'h38};
    vt[12] = '{1'b1, 3'd1, 8'hFF, 8'h20};
    vt[13] = '{1'b1, 3'd5, 8'h77, 8'h00};

    do_reset();
    check("reset_tx", 16'(tx), 16'd1);
    check("reset_inter", 16'(inter), 16'd0);
    for (int i = 0; i < 14; i++) begin
      if (vt[i].w) wr(1'b0, vt[i].a, vt[i].d);
      rd(vt[i].a, d);
      check($sformatf("reg%0d", i), 16'(d), 16'(vt[i].e));
    end
    check("table_tx", 16'(tx), 16'd1);
    check("table_inter", 16'(inter), 16'd0);

    round(7'h40, 8'd0, 1, 8'd1, 8'hA5, "lb_a5");
    round(7'h40, 8'd0, 17, 8'd1, 8'($urandom), "overrun");

    // Parity error on an externally driven frame: 0x03 with a wrong even-parity bit.
    do_reset();
    wr(1'b0, 3'd2, 8'h1C);
    build_frame(8'h03, 8, 1'b1, 1'b1, 1'b0, len, b);
    b[9] = 1'b1;
    for (int k = 0; k < len; k++) begin
      rx = b[k];
      repeat (8) @(negedge clk);
    end
    rx = 1'b1;
    wait_status(0, "par_rx");
    rd(3'd1, d);
    check("par_status", 16'(d), 16'h65);
    check("par_inter", 16'(inter), 16'd1);
    rd(3'd0, d);
    check("par_data", 16'(d), 16'h03);
    wr(1'b0, 3'd1, 8'h04);
    check("par_inter_lag", 16'(inter), 16'd1);
    @(negedge clk);
    check("par_inter_clr", 16'(inter), 16'd0);
    rd(3'd1, d);
    check("par_status_clr", 16'(d), 16'h20);

    // TX overflow with a slow baud: first byte in flight, then 16 fill the FIFO, the next is dropped.
    do_reset();
    wr(1'b0, 3'd3, 8'hE8);
    wr(1'b0, 3'd4, 8'h03);
    wr(1'b0, 3'd0, 8'h11);
    wait_fall(1'b0, ok);
    check("ovf_pop", 16'(ok), 16'd1);
    for (int i = 0; i < 16; i++) wr(1'b0, 3'd0, 8'(i));
    rd(3'd1, d);
    check("ovf_full", 16'(d), 16'h10);
    wr(1'b0, 3'd0, 8'hEE);
    rd(3'd1, d);
    check("ovf_flag", 16'(d), 16'h90);
    rd(3'd6, d);
    check("ovf_level", 16'(d), 16'd16);
    wr(1'b0, 3'd2, 8'h80);
    rd(3'd6, d);
    check("flush_level", 16'(d), 16'd0);
    rd(3'd2, d);
    check("flush_ctrl", 16'(d), 16'd0);
    wr(1'b0, 3'd1, 8'h80);
    rd(3'd1, d);
    check("ovf_w1c", 16'(d), 16'h00);

    // 7 data bits, odd parity, two stop bits.
    do_reset();
    wr(1'b1, 3'd2, 8'h28);
    wr(1'b1, 3'd0, 8'h41);
    cap("b7", 1'b1, 1, 11, 16'h0782);
    @(negedge clk);
    adr = 3'd2;
    #1 check("b7_ctrl", 16'(dat_o7), 16'h28);
    check("b7_inter", 16'(inter7), 16'd0);

    // Reset in the middle of a frame.
    do_reset();
    wr(1'b0, 3'd0, 8'h00);
    wait_fall(1'b0, ok);
    check("rst_start", 16'(ok), 16'd1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_tx", 16'(tx), 16'd1);
    rst = 1'b0;
    rd(3'd1, d);
    check("rst_status", 16'(d), 16'h20);

    for (int r = 0; r < 6; r++)
      round(7'($urandom) | 7'h40, 8'($urandom_range(0, 2)), int'($urandom_range(1, 17)),
            8'($urandom_range(1, 16)), 8'($urandom), $sformatf("rnd%0d", r));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
